fp_cast_arbiter: RTL and testbench

- Shares one float/int cast unit (i2f / f2i, fixed latency, Ready always high) between NB_CORES requesting cores.
- Arbitrates requests round-robin and drives the cast unit's enable, operand, direction, rounding-mode and tag inputs.
- Tracks outstanding operations per core and routes each returning result back to its core using the tag.
- Sits in the shared APU cluster between the core-side request ports and the cast unit instance.

---
 rtl/fp_cast_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fp_cast_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cast_arbiter.sv
// Round-robin arbiter sharing one fixed-latency float/int cast unit between NB_CORES cores.
// Optional macro FP_CAST_ARB_PRIO_EN adds prio_i: prioritised cores compete first on the shared pointer.
module fp_cast_arbiter #(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned FP_WIDTH        = 32,
    parameter int unsigned RND_WIDTH       = 3,
    parameter int unsigned STAT_WIDTH      = 5,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TAG_WIDTH       = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NB_CORES-1:0]           req_i,
`ifdef FP_CAST_ARB_PRIO_EN
    input  logic [NB_CORES-1:0]           prio_i,
`endif
    output logic [NB_CORES-1:0]           gnt_o,
    input  logic [NB_CORES*FP_WIDTH-1:0]  opa_i,
    input  logic [NB_CORES-1:0]           f2i_i,
    input  logic [NB_CORES*RND_WIDTH-1:0] rnd_i,
    output logic [NB_CORES-1:0]           resp_valid_o,
    output logic [FP_WIDTH-1:0]           result_o,
    output logic [STAT_WIDTH-1:0]         status_o,
    output logic                          cast_en_o,
    output logic                          cast_f2i_o,
    output logic [FP_WIDTH-1:0]           cast_opa_o,
    output logic [RND_WIDTH-1:0]          cast_rnd_o,
    output logic [TAG_WIDTH-1:0]          cast_tag_o,
    input  logic                          cast_ready_i,
    input  logic                          cast_valid_i,
    input  logic [TAG_WIDTH-1:0]          cast_tag_i,
    input  logic [FP_WIDTH-1:0]           cast_res_i,
    input  logic [STAT_WIDTH-1:0]         cast_status_i,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int unsigned CNT_WIDTH = 3;
    localparam int unsigned SUM_WIDTH = TAG_WIDTH + 1;

    logic [TAG_WIDTH-1:0] rr_ptr_q;
    logic [CNT_WIDTH-1:0] cnt_q [NB_CORES];
    logic                 err_q;

    logic [NB_CORES-1:0]  resp_hit;
    logic                 resp_bad;
    logic [NB_CORES-1:0]  elig;
    logic [NB_CORES-1:0]  cand;
    logic [NB_CORES-1:0]  cand_rot;
    logic                 gnt_found;
    logic                 gnt_valid;
    logic [TAG_WIDTH-1:0] gnt_off;
    logic [SUM_WIDTH-1:0] gnt_sum;
    logic [TAG_WIDTH-1:0] gnt_idx;

    // A response is accepted only for a real core that has something in flight
    always_comb begin
        resp_hit = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            resp_hit[k] = cast_valid_i && (cast_tag_i == TAG_WIDTH'(k)) && (cnt_q[k] != '0);
        end
        resp_bad = cast_valid_i && !(|resp_hit);
    end

    // Same-cycle responses free a slot immediately, so a full core can be granted again at once
    always_comb begin
        elig = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            elig[k] = req_i[k] && cast_ready_i &&
                      ((cnt_q[k] - CNT_WIDTH'(resp_hit[k])) < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

`ifdef FP_CAST_ARB_PRIO_EN
    assign cand = (|(elig & prio_i)) ? (elig & prio_i) : elig;
`else
    assign cand = elig;
`endif

    // Rotate candidates so the pointer sits at bit 0, pick the lowest set bit, rotate back
    always_comb begin
        cand_rot  = NB_CORES'({cand, cand} >> rr_ptr_q);
        gnt_found = 1'b0;
        gnt_off   = '0;
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            if (cand_rot[i]) begin
                gnt_found = 1'b1;
                gnt_off   = TAG_WIDTH'(i);
            end
        end
        gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
        gnt_idx = (gnt_sum >= SUM_WIDTH'(NB_CORES)) ? TAG_WIDTH'(gnt_sum - SUM_WIDTH'(NB_CORES))
                                                    : TAG_WIDTH'(gnt_sum);
    end

    assign gnt_valid = gnt_found && !rst_i;

    always_comb begin
        gnt_o      = '0;
        cast_en_o  = 1'b0;
        cast_f2i_o = 1'b0;
        cast_opa_o = '0;
        cast_rnd_o = '0;
        cast_tag_o = '0;
        if (gnt_valid) begin
            gnt_o      = NB_CORES'(1) << gnt_idx;
            cast_en_o  = 1'b1;
            cast_f2i_o = f2i_i[gnt_idx];
            cast_opa_o = opa_i[gnt_idx*FP_WIDTH +: FP_WIDTH];
            cast_rnd_o = rnd_i[gnt_idx*RND_WIDTH +: RND_WIDTH];
            cast_tag_o = gnt_idx;
        end
    end

    assign resp_valid_o = resp_hit;
    assign result_o     = (|resp_hit) ? cast_res_i : '0;
    assign status_o     = (|resp_hit) ? cast_status_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (gnt_valid) begin
            rr_ptr_q <= (gnt_idx == TAG_WIDTH'(NB_CORES - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Per-core outstanding counters; grant and response together cancel out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NB_CORES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NB_CORES; k++) begin
                case ({gnt_o[k], resp_hit[k]})
                    2'b10:   cnt_q[k] <= cnt_q[k] + 1'b1;
                    2'b01:   cnt_q[k] <= cnt_q[k] - 1'b1;
                    default: cnt_q[k] <= cnt_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (resp_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < NB_CORES; k++) begin
            busy_o = busy_o | (cnt_q[k] != '0);
        end
    end

endmodule

// File: tb/tb_fp_cast_arbiter.sv
// Self-checking bench for fp_cast_arbiter with a depth-1 cast unit stand-in.
`timescale 1ns/1ps
module tb_fp_cast_arbiter;

    localparam int N    = 4;
    localparam int FPW  = 32;
    localparam int RW   = 3;
    localparam int SW   = 5;
    localparam int MAXO = 2;
    localparam int TW   = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i, f2i_i, prio_i, gnt_o, resp_valid_o;
    logic [N*FPW-1:0] opa_i;
    logic [N*RW-1:0] rnd_i;
    logic [FPW-1:0]  result_o, cast_opa_o, cast_res_i;
    logic [SW-1:0]   status_o, cast_status_i;
    logic            cast_en_o, cast_f2i_o, cast_ready_i, cast_valid_i, busy_o, err_o;
    logic [RW-1:0]   cast_rnd_o;
    logic [TW-1:0]   cast_tag_o, cast_tag_i;

    int checks = 0;
    int errors = 0;

    // manual override of the cast unit return path
    logic            man_mode, man_v;
    logic [TW-1:0]   man_tag;
    logic [FPW-1:0]  man_res;

    logic            pv;
    logic [TW-1:0]   ptag;
    logic [FPW-1:0]  pres;
    logic [SW-1:0]   pst;

    fp_cast_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
`ifdef FP_CAST_ARB_PRIO_EN
        .prio_i(prio_i),
`endif
        .gnt_o(gnt_o), .opa_i(opa_i), .f2i_i(f2i_i), .rnd_i(rnd_i),
        .resp_valid_o(resp_valid_o), .result_o(result_o), .status_o(status_o),
        .cast_en_o(cast_en_o), .cast_f2i_o(cast_f2i_o), .cast_opa_o(cast_opa_o),
        .cast_rnd_o(cast_rnd_o), .cast_tag_o(cast_tag_o), .cast_ready_i(cast_ready_i),
        .cast_valid_i(cast_valid_i), .cast_tag_i(cast_tag_i), .cast_res_i(cast_res_i),
        .cast_status_i(cast_status_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // f2i truncates positive floats; i2f is a recognisable scramble of the operand
    function automatic logic [FPW-1:0] cast_fn(input logic f2i, input logic [FPW-1:0] a);
        int e;
        logic [FPW-1:0] m;
        if (!f2i) return a ^ 32'h5A5A_5A5A;
        e = int'(a[30:23]) - 127;
        m = {8'h00, 1'b1, a[22:0]};
        if (e < 0)   return '0;
        if (e <= 23) return m >> (23 - e);
        if (e <= 31) return m << (e - 23);
        return 32'hFFFF_FFFF;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pv <= 1'b0; ptag <= '0; pres <= '0; pst <= '0;
        end else begin
            pv   <= cast_en_o;
            ptag <= cast_tag_o;
            pres <= cast_fn(cast_f2i_o, cast_opa_o);
            pst  <= cast_opa_o[31:27];
        end
    end

    always_comb begin
        cast_valid_i  = man_mode ? man_v   : pv;
        cast_tag_i    = man_mode ? man_tag : ptag;
        cast_res_i    = man_mode ? man_res : pres;
        cast_status_i = man_mode ? '0      : pst;
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic set_core(input int k, input logic [FPW-1:0] a, input logic f, input logic [RW-1:0] r);
        opa_i[k*FPW +: FPW] = a;
        f2i_i[k]            = f;
        rnd_i[k*RW +: RW]   = r;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1; req_i = '0; prio_i = '0; man_mode = 1'b0; man_v = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 4'b1111; prio_i = '0; cast_ready_i = 1'b1;
        man_mode = 1'b0; man_v = 1'b0; man_tag = '0; man_res = '0;
        opa_i = '1; f2i_i = '0; rnd_i = '0;
        #1;
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", gnt_o); end
        checks++; if (cast_en_o !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", cast_en_o); end
        checks++; if (cast_opa_o !== '0) begin errors++; $display("FAIL rst_opa got %h exp 0", cast_opa_o); end
        checks++; if (resp_valid_o !== 4'b0000) begin errors++; $display("FAIL rst_resp got %b exp 0000", resp_valid_o); end
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rst_busy_err got %b%b exp 00", busy_o, err_o); end
        checks++; if (result_o !== '0) begin errors++; $display("FAIL rst_result got %h exp 0", result_o); end
        tick();
        rst_i = 1'b0; req_i = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [FPW-1:0] ops [N];
        for (int k = 0; k < N; k++) begin
            ops[k] = 32'h1111_0000 * (k + 1) + 32'(k);
            set_core(k, ops[k], 1'b0, 3'(k));
        end
        for (int i = 0; i <= N; i++) begin
            req_i = (i < N) ? 4'b1111 : 4'b0000;
            #1;
            if (i < N) begin
                checks++; if (gnt_o !== 4'(1 << i)) begin errors++; $display("FAIL rr_gnt step %0d got %b exp %b", i, gnt_o, 4'(1 << i)); end
                checks++; if (cast_tag_o !== TW'(i)) begin errors++; $display("FAIL rr_tag step %0d got %0d exp %0d", i, cast_tag_o, i); end
            end
            if (i > 0) begin
                checks++; if (resp_valid_o !== 4'(1 << (i - 1))) begin errors++; $display("FAIL rr_resp step %0d got %b exp %b", i, resp_valid_o, 4'(1 << (i - 1))); end
                checks++; if (result_o !== cast_fn(1'b0, ops[i-1])) begin errors++; $display("FAIL rr_result step %0d got %h exp %h", i, result_o, cast_fn(1'b0, ops[i-1])); end
            end else begin
                checks++; if (resp_valid_o !== 4'b0000) begin errors++; $display("FAIL rr_resp0 got %b exp 0000", resp_valid_o); end
            end
            tick();
        end
    endtask

    task automatic test_cast_path();
        set_core(2, 32'h4049_0FDB, 1'b1, 3'b001);
        req_i = 4'b0100;
        #1;
        checks++; if (gnt_o !== 4'b0100 || cast_tag_o !== 2'd2 || cast_en_o !== 1'b1) begin errors++; $display("FAIL cp_grant got gnt %b tag %0d en %b exp 0100 2 1", gnt_o, cast_tag_o, cast_en_o); end
        checks++; if (cast_opa_o !== 32'h4049_0FDB || cast_f2i_o !== 1'b1 || cast_rnd_o !== 3'b001) begin errors++; $display("FAIL cp_operands got %h %b %b exp 40490fdb 1 001", cast_opa_o, cast_f2i_o, cast_rnd_o); end
        tick();
        req_i = '0;
        #1;
        checks++; if (resp_valid_o !== 4'b0100) begin errors++; $display("FAIL cp_resp got %b exp 0100", resp_valid_o); end
        checks++; if (result_o !== 32'h0000_0003) begin errors++; $display("FAIL cp_result got %h exp 00000003", result_o); end
        checks++; if (status_o !== 5'b01000) begin errors++; $display("FAIL cp_status got %b exp 01000", status_o); end
        tick();
    endtask

    task automatic test_full();
        man_mode = 1'b1; man_v = 1'b0; man_tag = 2'd1; man_res = 32'h0000_CAFE;
        req_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (gnt_o !== ((i < MAXO) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL full_gnt step %0d got %b exp %b", i, gnt_o, (i < MAXO) ? 4'b0010 : 4'b0000); end
            tick();
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy_o); end
        man_v = 1'b1;
        #1;
        checks++; if (resp_valid_o !== 4'b0010 || gnt_o !== 4'b0010) begin errors++; $display("FAIL full_reopen got resp %b gnt %b exp 0010 0010", resp_valid_o, gnt_o); end
        checks++; if (result_o !== 32'h0000_CAFE) begin errors++; $display("FAIL full_result got %h exp 0000cafe", result_o); end
        tick();
        req_i = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (resp_valid_o !== 4'b0010) begin errors++; $display("FAIL full_drain step %0d got %b exp 0010", i, resp_valid_o); end
            tick();
        end
        man_v = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL full_idle got busy %b err %b exp 0 0", busy_o, err_o); end
        man_mode = 1'b0;
        tick();
    endtask

    task automatic test_error();
        man_mode = 1'b1; man_v = 1'b1; man_tag = 2'd3; man_res = 32'h1234_5678;
        req_i = '0;
        #1;
        checks++; if (resp_valid_o !== 4'b0000) begin errors++; $display("FAIL err_resp got %b exp 0000", resp_valid_o); end
        tick();
        man_v = 1'b0;
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL err_no_underflow got busy %b exp 0", busy_o); end
        tick(); tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
        man_mode = 1'b0;
    endtask

    task automatic test_reset_midop();
        man_mode = 1'b1; man_v = 1'b0;
        req_i = 4'b1111;
        tick(); tick();
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0 || gnt_o !== 4'b0000 || resp_valid_o !== 4'b0000 || err_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset got busy %b gnt %b resp %b err %b exp 0 0000 0000 0", busy_o, gnt_o, resp_valid_o, err_o);
        end
        tick();
        rst_i = 1'b0; man_mode = 1'b0;
        #1;
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b exp 0001", gnt_o); end
        tick();
        req_i = '0;
        #1;
        checks++; if (resp_valid_o !== 4'b0001) begin errors++; $display("FAIL mid_resp got %b exp 0001", resp_valid_o); end
        tick();
        #1;
        checks++; if (resp_valid_o !== 4'b0000 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_quiet got resp %b busy %b exp 0000 0", resp_valid_o, busy_o); end
        tick();
    endtask

`ifdef FP_CAST_ARB_PRIO_EN
    task automatic test_prio();
        logic [N-1:0] exp_seq [4];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b1000;
        apply_reset();
        req_i = 4'b1111; prio_i = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (gnt_o !== exp_seq[i]) begin errors++; $display("FAIL prio_gnt step %0d got %b exp %b", i, gnt_o, exp_seq[i]); end
            tick();
        end
        req_i = '0; prio_i = '0;
        tick();
    endtask
`endif

    // Reference: scoreboard of in-flight counts, pointer as an integer, nearest-after-pointer wins
    task automatic test_random();
        int m_ptr;
        int m_cnt [N];
        int m_prev;
        logic [FPW-1:0] m_prev_res;
        logic [SW-1:0]  m_prev_st;
        int best, bestd, d, free_slots;
        logic [N-1:0] pool, hi, exp_gnt, exp_resp;
        logic exp_busy;

        apply_reset();
        m_ptr = 0; m_prev = -1; m_prev_res = '0; m_prev_st = '0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;

        for (int c = 0; c < 400; c++) begin
            req_i        = 4'($urandom_range(0, 15));
            cast_ready_i = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < N; k++)
                set_core(k, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
`ifdef FP_CAST_ARB_PRIO_EN
            prio_i = 4'($urandom_range(0, 15));
`endif
            #1;
            exp_busy = 1'b0;
            for (int k = 0; k < N; k++) if (m_cnt[k] != 0) exp_busy = 1'b1;
            exp_resp = (m_prev >= 0) ? 4'(1 << m_prev) : 4'b0000;

            pool = '0;
            for (int k = 0; k < N; k++) begin
                free_slots = MAXO - m_cnt[k] + ((k == m_prev) ? 1 : 0);
                pool[k] = req_i[k] && cast_ready_i && (free_slots > 0);
            end
            hi = pool;
`ifdef FP_CAST_ARB_PRIO_EN
            if ((pool & prio_i) != '0) hi = pool & prio_i;
`endif
            best = -1; bestd = N;
            for (int k = 0; k < N; k++) begin
                d = (k - m_ptr + N) % N;
                if (hi[k] && d < bestd) begin best = k; bestd = d; end
            end
            exp_gnt = (best >= 0) ? 4'(1 << best) : 4'b0000;

            checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc %0d got %b exp %b", c, gnt_o, exp_gnt); end
            checks++; if (resp_valid_o !== exp_resp) begin errors++; $display("FAIL rnd_resp cyc %0d got %b exp %b", c, resp_valid_o, exp_resp); end
            checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, busy_o, exp_busy); end
            if (m_prev >= 0) begin
                checks++; if (result_o !== m_prev_res || status_o !== m_prev_st) begin
                    errors++; $display("FAIL rnd_result cyc %0d got %h/%b exp %h/%b", c, result_o, status_o, m_prev_res, m_prev_st);
                end
            end
            if (best >= 0) begin
                checks++; if (cast_tag_o !== TW'(best) || cast_opa_o !== opa_i[best*FPW +: FPW] || cast_rnd_o !== rnd_i[best*RW +: RW]) begin
                    errors++; $display("FAIL rnd_cast cyc %0d got tag %0d opa %h rnd %b exp %0d", c, cast_tag_o, cast_opa_o, cast_rnd_o, best);
                end
            end

            if (m_prev >= 0) m_cnt[m_prev]--;
            if (best >= 0) begin
                m_cnt[best]++;
                m_ptr      = (best + 1) % N;
                m_prev_res = cast_fn(f2i_i[best], opa_i[best*FPW +: FPW]);
                m_prev_st  = opa_i[best*FPW + 27 +: SW];
            end
            m_prev = best;
            tick();
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rnd_err got %b exp 0", err_o); end
        req_i = '0;
        cast_ready_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_cast_path();
        test_full();
        test_error();
        test_reset_midop();
`ifdef FP_CAST_ARB_PRIO_EN
        test_prio();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
